// File: rtl/filtro_pkg.sv
// Shared constants and state encoding for the second-order recursive filter.
// Samples and coefficients are Q8.14 signed.
package filtro_pkg;

    localparam int unsigned WIDTH  = 22;
    localparam int unsigned FRAC   = 14;
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned ACC_W  = 2 * WIDTH + 3;

    localparam logic [WIDTH-1:0] MAX_Q = 22'h1FFFFF;
    localparam logic [WIDTH-1:0] MIN_Q = 22'h200000;
    localparam logic [WIDTH-1:0] UNO_Q = 22'd16384;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        FIN  = 2'd2
    } estado_t;

endpackage

// File: rtl/filtro_recursivo_secuencial_if.sv
// Sample handshake, coefficient inputs and filtered output of the recursive filter.
interface filtro_recursivo_secuencial_if;

    logic                                       limpiar;
    logic                                       in_valid;
    logic                                       in_ready;
    logic signed [filtro_pkg::WIDTH-1:0]        x_in;
    logic signed [filtro_pkg::WIDTH-1:0]        coef_b0;
    logic signed [filtro_pkg::WIDTH-1:0]        coef_b1;
    logic signed [filtro_pkg::WIDTH-1:0]        coef_b2;
    logic signed [filtro_pkg::WIDTH-1:0]        coef_a1;
    logic signed [filtro_pkg::WIDTH-1:0]        coef_a2;
    logic signed [filtro_pkg::WIDTH-1:0]        y_out;
    logic                                       out_valid;
    logic                                       saturado;

    modport master (
        output limpiar, in_valid, x_in, coef_b0, coef_b1, coef_b2, coef_a1, coef_a2,
        input  in_ready, y_out, out_valid, saturado
    );

    modport slave (
        input  limpiar, in_valid, x_in, coef_b0, coef_b1, coef_b2, coef_a1, coef_a2,
        output in_ready, y_out, out_valid, saturado
    );

endinterface

// File: rtl/saturador_q8_14.sv
// Drops FRAC fraction bits from the accumulator (floor) and clips to the Q8.14 range.
module saturador_q8_14
    import filtro_pkg::*;
(
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [WIDTH-1:0] o_y,
    output logic                    o_sat
);

    localparam logic signed [ACC_W-1:0] LIM_POS = {{(ACC_W - WIDTH){1'b0}}, MAX_Q};
    localparam logic signed [ACC_W-1:0] LIM_NEG = {{(ACC_W - WIDTH){1'b1}}, MIN_Q};

    logic signed [ACC_W-1:0] w_shift;

    always_comb begin
        w_shift = i_acc >>> FRAC;
        o_y     = w_shift[WIDTH-1:0];
        o_sat   = 1'b0;
        if (w_shift > LIM_POS) begin
            o_y   = MAX_Q;
            o_sat = 1'b1;
        end else if (w_shift < LIM_NEG) begin
            o_y   = MIN_Q;
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/filtro_recursivo_secuencial.sv
// Direct form I biquad with one shared multiplier, five MAC cycles per accepted sample.
// Feedback history always stores the saturated output.
module filtro_recursivo_secuencial
    import filtro_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    filtro_recursivo_secuencial_if.slave  bus
);

    estado_t                 r_estado;
    estado_t                 w_estado_d;
    logic [2:0]              r_idx;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [WIDTH-1:0] r_x0, r_x1, r_x2, r_y1, r_y2;
    logic signed [WIDTH-1:0] r_b0, r_b1, r_b2, r_a1, r_a2;
    logic signed [WIDTH-1:0] r_y_out;
    logic                    r_out_valid;
    logic                    r_saturado;

    logic signed [WIDTH-1:0]  w_coef;
    logic signed [WIDTH-1:0]  w_dato;
    logic signed [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]         w_prod_ext;
    logic signed [WIDTH-1:0]  w_y_sat;
    logic                     w_sat;

    always_comb begin
        case (r_idx)
            3'd0:    begin w_coef = r_b0; w_dato = r_x0; end
            3'd1:    begin w_coef = r_b1; w_dato = r_x1; end
            3'd2:    begin w_coef = r_b2; w_dato = r_x2; end
            3'd3:    begin w_coef = r_a1; w_dato = r_y1; end
            default: begin w_coef = r_a2; w_dato = r_y2; end
        endcase
    end

    assign w_prod     = w_coef * w_dato;
    assign w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};

    saturador_q8_14 u_saturador (
        .i_acc (r_acc),
        .o_y   (w_y_sat),
        .o_sat (w_sat)
    );

    always_comb begin
        w_estado_d = r_estado;
        case (r_estado)
            IDLE:    if (bus.in_valid) w_estado_d = MAC;
            MAC:     if (r_idx == 3'd4) w_estado_d = FIN;
            FIN:     w_estado_d = IDLE;
            default: w_estado_d = IDLE;
        endcase
        if (bus.limpiar) w_estado_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_estado <= IDLE;
        else        r_estado <= w_estado_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx       <= 3'd0;
            r_acc       <= '0;
            r_x0        <= '0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_y1        <= '0;
            r_y2        <= '0;
            r_b0        <= '0;
            r_b1        <= '0;
            r_b2        <= '0;
            r_a1        <= '0;
            r_a2        <= '0;
            r_y_out     <= '0;
            r_out_valid <= 1'b0;
            r_saturado  <= 1'b0;
        end else if (bus.limpiar) begin
            // y_out and saturado keep describing the last delivered sample
            r_idx       <= 3'd0;
            r_acc       <= '0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_y1        <= '0;
            r_y2        <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_estado)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_x0  <= bus.x_in;
                        r_b0  <= bus.coef_b0;
                        r_b1  <= bus.coef_b1;
                        r_b2  <= bus.coef_b2;
                        r_a1  <= bus.coef_a1;
                        r_a2  <= bus.coef_a2;
                        r_acc <= '0;
                        r_idx <= 3'd0;
                    end
                end
                MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_idx <= r_idx + 3'd1;
                end
                FIN: begin
                    r_y_out     <= w_y_sat;
                    r_saturado  <= w_sat;
                    r_out_valid <= 1'b1;
                    r_x2        <= r_x1;
                    r_x1        <= r_x0;
                    r_y2        <= r_y1;
                    r_y1        <= w_y_sat;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_estado == IDLE);
    assign bus.y_out     = r_y_out;
    assign bus.out_valid = r_out_valid;
    assign bus.saturado  = r_saturado;

endmodule
